// File: rtl/crc_pkg.sv
// Shared CRC-8 constants and the single-bit remainder step used by the
// serial generator, and later by the byte-wise CRC and the receiver checker.
package crc_pkg;

  localparam int                   CRC_WIDTH = 8;
  localparam logic [CRC_WIDTH-1:0] CRC_POLY  = 8'h07;
  localparam logic [CRC_WIDTH-1:0] CRC_INIT  = 8'h00;

  typedef logic [CRC_WIDTH-1:0] crc_t;

  // Non-reflected MSB-first step; the implicit x^WIDTH term is the feedback bit.
  function automatic crc_t crc_step_poly(input crc_t crc, input logic bit_v, input crc_t poly);
    logic fb;
    fb = crc[CRC_WIDTH-1] ^ bit_v;
    return {crc[CRC_WIDTH-2:0], 1'b0} ^ (fb ? poly : '0);
  endfunction

  function automatic crc_t crc_step(input crc_t crc, input logic bit_v);
    return crc_step_poly(crc, bit_v, CRC_POLY);
  endfunction

endpackage

// File: rtl/crc_create.sv
// Bit-serial CRC-8 generator: absorbs one bit per enabled clock, MSB first.
// crc is registered and updates one clock after the sampling edge; no backpressure.
module crc_create
  import crc_pkg::*;
#(
  parameter int               WIDTH    = CRC_WIDTH,
  parameter logic [WIDTH-1:0] POLY     = CRC_POLY,
  parameter logic [WIDTH-1:0] INIT_VAL = CRC_INIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             init,
  input  logic             enable,
  output logic [WIDTH-1:0] crc
);

  logic [WIDTH-1:0] crc_q;
  logic [WIDTH-1:0] crc_d;

  // init outranks enable so the frame builder can re-seed on any cycle.
  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = INIT_VAL;
    end else if (enable) begin
      crc_d = crc_step_poly(crc_q, bit_in, POLY);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc_q <= INIT_VAL;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: tb/tb_crc_create.sv
// Directed and random checks of crc_create against hand values and crc_step.
module tb_crc_create;
  import crc_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       bit_in = 1'b0;
  logic       init = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] crc;

  logic       sample_req = 1'b0;
  logic       mon_req;
  logic [7:0] model = 8'h00;
  logic [7:0] exp_q[$];
  string      name_q[$];
  int         vectors = 0;
  int         miscompares = 0;

  crc_create dut (
    .clk    (clk),
    .rst    (rst),
    .bit_in (bit_in),
    .init   (init),
    .enable (enable),
    .crc    (crc)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: crc=%h expected=%h", nm, act, exp);
    end
  endtask

  // Drive one cycle on the falling edge; optionally queue the value crc must
  // show after the following rising edge.
  task automatic drive(input logic ini, input logic en, input logic b,
                       input logic chk, input logic [7:0] exp, input string nm);
    @(negedge clk);
    init       = ini;
    enable     = en;
    bit_in     = b;
    sample_req = chk;
    if (ini) model = 8'h00;
    else if (en) model = crc_step(model, b);
    if (chk) begin
      exp_q.push_back(exp);
      name_q.push_back(nm);
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) drive(1'b0, 1'b1, v[i], 1'b0, 8'h00, "");
  endtask

  task automatic byte_case(input logic [7:0] v, input logic [7:0] exp, input string nm);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "");
    send_byte(v);
    drive(1'b0, 1'b0, 1'b0, 1'b1, exp, nm);
  endtask

  // Monitor: compares after each rising edge where the consumer asked for a check.
  always @(posedge clk) begin
    mon_req = sample_req;
    #1;
    if (mon_req) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL scoreboard_empty: crc=%h expected=<none>", crc);
      end else begin
        cmp(name_q.pop_front(), crc, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1;
    cmp("reset_hold", crc, 8'h00);
    repeat (2) @(negedge clk);
    cmp("reset_hold_clk", crc, 8'h00);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, "idle");

    byte_case(8'hA2, 8'h67, "byte_a2");
    byte_case(8'h01, 8'h07, "byte_01");
    byte_case(8'hFF, 8'hF3, "byte_ff");
    byte_case(8'h00, 8'h00, "byte_00");

    // Asynchronous reset mid-stream, observed before any further clock edge.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "");
    send_byte(8'hFF);
    @(negedge clk);
    enable     = 1'b0;
    sample_req = 1'b0;
    #2 rst = 1'b0;
    #1 cmp("rst_async", crc, 8'h00);
    model = 8'h00;
    @(negedge clk);
    cmp("rst_held", crc, 8'h00);
    rst = 1'b1;

    // "123456789" continuous, then with random enable gaps.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "");
    for (int k = 0; k < 9; k++) send_byte(8'h31 + 8'(k));
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hF4, "check_123456789");
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "");
    for (int k = 0; k < 9; k++) begin
      logic [7:0] ch;
      ch = 8'h31 + 8'(k);
      for (int i = 7; i >= 0; i--) begin
        if ($urandom_range(0, 2) == 0)
          drive(1'b0, 1'b0, 1'($urandom), 1'b0, 8'h00, "");
        drive(1'b0, 1'b1, ch[i], 1'b0, 8'h00, "");
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hF4, "check_gaps");

    // init wins over enable, then restart and hold.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "");
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, "");
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, "init_priority");
    send_byte(8'hA2);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h67, "restart_a2");
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'(i), 1'b1, 8'h67, "hold");

    // Random-length streams checked against the reference step every cycle.
    for (int s = 0; s < 1000; s++) begin
      int len;
      len = $urandom_range(1, 128);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, "rand_init");
      for (int i = 0; i < len; i++) begin
        logic b;
        b = 1'($urandom);
        drive(1'b0, 1'b1, b, 1'b1, crc_step(model, b), "rand_bit");
      end
    end

    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "");
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain: pending=%0d expected=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
